pe_seq_ctrl: RTL and testbench

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_seq_ctrl_if.sv | 24 ++
 rtl/pe_pix_cnt.sv | 39 +++
 rtl/pe_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the PE sequencer.
// Holds the FSM state enum, kernel tap count and counter widths.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADW,
    CTRL,
    RUN,
    DONE
  } state_t;

  // 3x3 kernel: nine weight beats per frame
  localparam int KTAPS  = 9;
  localparam int TAP_W  = 4;
  localparam int STAT_W = 16;

  // Row/col counter width; a 1-line frame still needs one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: weight and pixel valid/ready handshakes.
// master drives valid/data (upstream), slave drives ready (sequencer).
interface pe_seq_ctrl_if #(
  parameter int CL_IN = 4,
  parameter int M     = 4
) ();

  logic                 wt_valid;
  logic [CL_IN*M-1:0]   wt_data;
  logic                 wt_ready;
  logic                 px_valid;
  logic                 px_ready;

  modport master (
    output wt_valid, wt_data, px_valid,
    input  wt_ready, px_ready
  );

  modport slave (
    input  wt_valid, wt_data, px_valid,
    output wt_ready, px_ready
  );

endinterface

// File: rtl/pe_pix_cnt.sv
// pe_pix_cnt: raster row/col counter for a LINES x LINES frame.
// Ports: clk, rst (async low), enable, clear (wins), row, col, last.
module pe_pix_cnt
  import pe_pkg::*;
#(
  parameter  int LINES = 16,
  localparam int CW    = cnt_w(LINES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [CW-1:0] MAXP = CW'(LINES - 1);

  assign last = (row == MAXP) && (col == MAXP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (enable) begin
      if (col == MAXP) begin
        col <= '0;
        row <= (row == MAXP) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: frame sequencer - load 9 weight taps, issue PE control,
// then stream LINES x LINES pixels.
// Ports: clk, rst (async low); start/abort + cfg_* frame request;
// bus (slave): wt_valid/wt_data/wt_ready, px_valid/px_ready;
// pe_w_in/pe_w_conf/pe_cntl_conf/pe_d_ch/pe_bp_ch/pe_bp_src to PE;
// row/col pixel position; busy/done/err status.
// Macro PE_SEQ_CTRL_STATS_EN adds frame_cnt and stall_cnt outputs.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter  int LINES = 16,
  parameter  int CL_IN = 4,
  parameter  int CL1   = 2,
  parameter  int M     = 4,
  localparam int CW    = cnt_w(LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CL_IN-1:0]   cfg_d_ch,
  input  logic [CL_IN-1:0]   cfg_bp_ch,
  input  logic [CL1-1:0]     cfg_bp_src,
  input  logic               abort,
  pe_seq_ctrl_if.slave       bus,
  output logic [CL_IN*M-1:0] pe_w_in,
  output logic               pe_w_conf,
  output logic               pe_cntl_conf,
  output logic [CL_IN-1:0]   pe_d_ch,
  output logic [CL_IN-1:0]   pe_bp_ch,
  output logic [CL1-1:0]     pe_bp_src,
  output logic [CW-1:0]      row,
  output logic [CW-1:0]      col,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef PE_SEQ_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]  frame_cnt,
  output logic [STAT_W-1:0]  stall_cnt
`endif
);

  state_t             state;
  logic [TAP_W-1:0]   tap;
  logic [CL_IN-1:0]   d_ch_q;
  logic [CL_IN-1:0]   bp_ch_q;
  logic [CL1-1:0]     bp_src_q;
  logic               px_acc;
  logic               last;
  logic               pix_clr;

  assign bus.wt_ready = (state == LOADW);
  assign bus.px_ready = (state == RUN);
  assign pe_w_conf    = bus.wt_valid & bus.wt_ready;
  assign pe_w_in      = bus.wt_data;
  assign pe_cntl_conf = (state == CTRL);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign px_acc       = bus.px_valid & bus.px_ready;
  // Counters restart from 0 on every RUN entry and on abort
  assign pix_clr      = (state != RUN) | abort;

  pe_pix_cnt #(.LINES(LINES)) u_pix (
    .clk    (clk),
    .rst    (rst),
    .enable (px_acc),
    .clear  (pix_clr),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tap       <= '0;
      d_ch_q    <= '0;
      bp_ch_q   <= '0;
      bp_src_q  <= '0;
      pe_d_ch   <= '0;
      pe_bp_ch  <= '0;
      pe_bp_src <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        tap   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              if (cfg_d_ch != '0) begin
                d_ch_q   <= cfg_d_ch;
                bp_ch_q  <= cfg_bp_ch;
                bp_src_q <= cfg_bp_src;
                tap      <= '0;
                state    <= LOADW;
              end else begin
                err <= 1'b1;
              end
            end
          end
          LOADW: begin
            if (pe_w_conf) begin
              if (tap == TAP_W'(KTAPS - 1)) begin
                tap   <= '0;
                state <= CTRL;
                // Present masks together with the CTRL strobe
                pe_d_ch   <= d_ch_q;
                pe_bp_ch  <= bp_ch_q;
                pe_bp_src <= bp_src_q;
              end else begin
                tap <= tap + TAP_W'(1);
              end
            end
          end
          CTRL: state <= RUN;
          RUN: begin
            if (px_acc && last)
              state <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PE_SEQ_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (done)
        frame_cnt <= frame_cnt + STAT_W'(1);
      if (state == CTRL)
        stall_cnt <= '0;
      else if (state == RUN && !bus.px_valid
               && stall_cnt != '1)
        stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: self-checking bench for pe_seq_ctrl.
// Start-request vector table, weight/pixel scoreboards, abort/reset.
`timescale 1ns/1ps
module tb_pe_seq_ctrl;

  localparam int LINES = 16;
  localparam int CL_IN = 4;
  localparam int CL1   = 2;
  localparam int M     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  cfg_d_ch = '0;
  logic [3:0]  cfg_bp_ch = '0;
  logic [1:0]  cfg_bp_src = '0;
  logic [15:0] pe_w_in;
  logic        pe_w_conf;
  logic        pe_cntl_conf;
  logic [3:0]  pe_d_ch;
  logic [3:0]  pe_bp_ch;
  logic [1:0]  pe_bp_src;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        busy;
  logic        done;
  logic        err;
`ifdef PE_SEQ_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] stall_cnt;
`endif

  pe_seq_ctrl_if #(.CL_IN(CL_IN), .M(M)) bus ();

  pe_seq_ctrl #(
    .LINES(LINES), .CL_IN(CL_IN), .CL1(CL1), .M(M)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_d_ch     (cfg_d_ch),
    .cfg_bp_ch    (cfg_bp_ch),
    .cfg_bp_src   (cfg_bp_src),
    .abort        (abort),
    .bus          (bus),
    .pe_w_in      (pe_w_in),
    .pe_w_conf    (pe_w_conf),
    .pe_cntl_conf (pe_cntl_conf),
    .pe_d_ch      (pe_d_ch),
    .pe_bp_ch     (pe_bp_ch),
    .pe_bp_src    (pe_bp_src),
    .row          (row),
    .col          (col),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef PE_SEQ_CTRL_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Scoreboards: expected weight words and pixel positions
  logic [15:0] wq[$];
  logic [7:0]  pq[$];
  int          w_pulses = 0;
  int          cntl_pulses = 0;
  int          done_pulses = 0;
  int          w_at_cntl = 0;
  logic [3:0]  cap_d, cap_bp;
  logic [1:0]  cap_src;

  always @(negedge clk) begin
    if (pe_w_conf) begin
      w_pulses++;
      if (wq.size() == 0) begin
        n_tot++;
        $display("FAIL w_unexpected: pe_w_in %0h", pe_w_in);
      end else begin
        chk("pe_w_in", 32'(pe_w_in), 32'(wq.pop_front()));
      end
    end
    if (pe_cntl_conf) begin
      cntl_pulses++;
      w_at_cntl = w_pulses;
      cap_d   = pe_d_ch;
      cap_bp  = pe_bp_ch;
      cap_src = pe_bp_src;
    end
    if (done) done_pulses++;
    if (bus.px_valid && bus.px_ready) begin
      if (pq.size() == 0) begin
        n_tot++;
        $display("FAIL px_unexpected: row %0d col %0d", row, col);
      end else begin
        chk("row_col", 32'({row, col}), 32'(pq.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] d,
                          input logic [3:0] bp,
                          input logic [1:0] src);
    cfg_d_ch   = d;
    cfg_bp_ch  = bp;
    cfg_bp_src = src;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n beats; 3-cycle gaps after beats gap_from..n-1 (0 = none)
  task automatic feed(input int n, input int gap_from);
    for (int k = 1; k <= n; k++) begin
      bus.wt_valid = 1'b1;
      bus.wt_data  = 16'(k * 16'h1111);
      wq.push_back(bus.wt_data);
      tick();
      if (gap_from != 0 && k >= gap_from && k < n) begin
        bus.wt_valid = 1'b0;
        repeat (3) begin
          chk("gap_wt_ready", 32'(bus.wt_ready), 32'd1);
          chk("gap_no_ctrl", 32'(pe_cntl_conf), 32'd0);
          tick();
        end
      end
    end
    bus.wt_valid = 1'b0;
  endtask

  // mode 0: all valid, 1: random valid + start probe, 2: 5 stalls
  task automatic run_px(input int n, input int mode,
                        output int stalls);
    int idx = 0;
    int sp = 0;
    int cyc = 0;
    int st[5] = '{3, 77, 128, 200, 254};
    logic v;
    stalls = 0;
    while (idx < n) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = ($urandom_range(0, 3) != 0);
      else if (sp < 5 && idx == st[sp]) begin
        v = 1'b0;
        sp++;
      end else v = 1'b1;
      start    = (mode == 1 && idx == 60);
      cfg_d_ch = 4'hF;
      bus.px_valid = v;
      if (v) pq.push_back({4'(idx / 16), 4'(idx % 16)});
      else stalls++;
      tick();
      if (v) idx++;
      cyc++;
      if (cyc > 4000) begin
        n_tot++;
        $display("FAIL run_timeout: idx %0d", idx);
        break;
      end
    end
    bus.px_valid = 1'b0;
    start = 1'b0;
  endtask

  typedef struct {
    logic       st;
    logic       ab;
    logic [3:0] d;
    logic       e_err;
    logic       e_busy;
  } vec_t;

  vec_t tbl[6];
  int   s;
  int   dp;
  int   wp;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b1};

    bus.wt_valid = 1'b0;
    bus.wt_data  = '0;
    bus.px_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_d_ch", 32'(pe_d_ch), 0);
    chk("rst_bp_ch", 32'(pe_bp_ch), 0);
    chk("rst_bp_src", 32'(pe_bp_src), 0);
    chk("rst_row_col", 32'({row, col}), 0);
    chk("rst_wt_ready", 32'(bus.wt_ready), 0);
    chk("rst_px_ready", 32'(bus.px_ready), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      start    = tbl[i].st;
      abort    = tbl[i].ab;
      cfg_d_ch = tbl[i].d;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      tick();
      chk($sformatf("tbl%0d_err_1cyc", i), 32'(err), 0);
      if (tbl[i].e_busy) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk($sformatf("tbl%0d_abort", i), 32'(busy), 0);
      end
    end

    // Frame 1: back-to-back weights, random pixel valid
    w_pulses = 0;
    cntl_pulses = 0;
    do_start(4'b0101, 4'b0011, 2'd2);
    chk("f1_wt_ready", 32'(bus.wt_ready), 1);
    feed(9, 0);
    chk("f1_cntl", 32'(pe_cntl_conf), 1);
    chk("f1_d_ch_ctrl", 32'(pe_d_ch), 32'h5);
    tick();
    chk("f1_cntl_once", 32'(pe_cntl_conf), 0);
    chk("f1_w_pulses", 32'(w_pulses), 9);
    chk("f1_wq_empty", 32'(wq.size()), 0);
    chk("f1_cntl_pulses", 32'(cntl_pulses), 1);
    chk("f1_w_at_cntl", 32'(w_at_cntl), 9);
    chk("f1_cap_d", 32'(cap_d), 32'h5);
    chk("f1_cap_bp", 32'(cap_bp), 32'h3);
    chk("f1_cap_src", 32'(cap_src), 2);
    chk("f1_px_ready", 32'(bus.px_ready), 1);
    chk("f1_rc0", 32'({row, col}), 0);
    dp = done_pulses;
    run_px(256, 1, s);
    chk("f1_done", 32'(done), 1);
    chk("f1_d_ch_hold", 32'(pe_d_ch), 32'h5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f1_done_1cyc", 32'(done), 0);
    chk("f1_idle", 32'(busy), 0);
    chk("f1_done_cnt", 32'(done_pulses - dp), 1);
    chk("f1_pq_empty", 32'(pq.size()), 0);
    chk("f1_cntl_total", 32'(cntl_pulses), 1);

    // Frame 2: gapped weights, exactly 5 stall cycles
    w_pulses = 0;
    cntl_pulses = 0;
    do_start(4'b1010, 4'b0100, 2'd1);
    feed(9, 4);
    tick();
    chk("f2_w_pulses", 32'(w_pulses), 9);
    chk("f2_w_at_cntl", 32'(w_at_cntl), 9);
    chk("f2_cntl_pulses", 32'(cntl_pulses), 1);
    chk("f2_cap_d", 32'(cap_d), 32'hA);
    chk("f2_cap_src", 32'(cap_src), 1);
    dp = done_pulses;
    run_px(256, 2, s);
    chk("f2_stalls_driven", 32'(s), 5);
    tick();
    chk("f2_done_cnt", 32'(done_pulses - dp), 1);
    chk("f2_idle", 32'(busy), 0);
`ifdef PE_SEQ_CTRL_STATS_EN
    chk("stat_frame_cnt", 32'(frame_cnt), 2);
    chk("stat_stall_cnt", 32'(stall_cnt), 5);
`endif

    // Abort at pixel 100, then reset in the middle of LOADW
    do_start(4'b0001, 4'b0010, 2'd3);
    feed(9, 0);
    tick();
    dp = done_pulses;
    run_px(100, 0, s);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_rc", 32'({row, col}), 0);
    chk("ab_pq_empty", 32'(pq.size()), 0);
    tick();
    chk("ab_no_done", 32'(done_pulses - dp), 0);
    wp = w_pulses;
    do_start(4'b1111, 4'b1111, 2'd3);
    feed(4, 0);
    chk("rl_busy_pre", 32'(busy), 1);
    chk("rl_w4", 32'(w_pulses - wp), 4);
    #2;
    rst = 1'b0;
    #1;
    chk("rl_busy", 32'(busy), 0);
    chk("rl_d_ch", 32'(pe_d_ch), 0);
    chk("rl_bp_ch", 32'(pe_bp_ch), 0);
    chk("rl_bp_src", 32'(pe_bp_src), 0);
    chk("rl_rc", 32'({row, col}), 0);
    chk("rl_wt_ready", 32'(bus.wt_ready), 0);
    chk("rl_err", 32'(err), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rl_idle", 32'(busy), 0);
    chk("rl_no_done", 32'(done_pulses - dp), 0);
    chk("rl_wq_empty", 32'(wq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
